// File: rtl/crg_pkg.sv
// Purpose: shared widths, FSM state enum and xoshiro256** state type for the seed expander.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package crg_pkg;

  localparam int WORD_W   = 64;
  localparam int N_WORDS  = 12;
  localparam int LEN_SEED = 4 * WORD_W;
  localparam int LEN_OUT  = N_WORDS * WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    FIN  = 2'd3
  } crg_state_t;

  // s3 is the most significant field so a 256-bit seed maps straight onto s0..s3
  typedef struct packed {
    logic [WORD_W-1:0] s3;
    logic [WORD_W-1:0] s2;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] s0;
  } xo_state_t;

  // 64-bit rotate left; k is always a constant 1..63 at the call sites
  function automatic logic [WORD_W-1:0] rotl64(input logic [WORD_W-1:0] x, input int unsigned k);
    return (x << k) | (x >> (WORD_W - k));
  endfunction

endpackage

// File: rtl/xoshiro256ss_step.sv
// Purpose: one combinational xoshiro256** step: output word from current state plus next state.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module xoshiro256ss_step
  import crg_pkg::*;
(
  input  xo_state_t         cur,
  output xo_state_t         nxt,
  output logic [WORD_W-1:0] result
);

  logic [WORD_W-1:0] s1_x5;
  logic [WORD_W-1:0] rot;
  logic [WORD_W-1:0] t;
  logic [WORD_W-1:0] s2_a;
  logic [WORD_W-1:0] s3_a;

  // Scrambler: rotl(s1*5, 7)*9 with the constant multiplies done as shift+add
  assign s1_x5  = (cur.s1 << 2) + cur.s1;
  assign rot    = rotl64(s1_x5, 7);
  assign result = (rot << 3) + rot;

  // Linear state update; the xor chain order matters (s1 uses updated s2, s0 uses updated s3)
  assign t      = cur.s1 << 17;
  assign s2_a   = cur.s2 ^ cur.s0;
  assign s3_a   = cur.s3 ^ cur.s1;
  assign nxt.s1 = cur.s1 ^ s2_a;
  assign nxt.s0 = cur.s0 ^ s3_a;
  assign nxt.s2 = s2_a ^ t;
  assign nxt.s3 = rotl64(s3_a, 45);

endmodule

// File: rtl/crg_prg_expander.sv
// Purpose: expands a 256-bit seed into 768 bits via twelve xoshiro256** steps (optional zero-seed trap: CRG_ZERO_SEED_CHECK_EN).
// Latency: 14 cycles run->done (2 with a trapped zero seed); one result per 15 cycles at most.
// Backpressure: none; run is only accepted in IDLE and ignored while busy or in FIN.
module crg_prg_expander
  import crg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [LEN_SEED-1:0] seed,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic                err_zero_seed,
  output logic [LEN_OUT-1:0]  dout
);

  crg_state_t        state;
  xo_state_t         xo;
  xo_state_t         xo_nxt;
  logic [WORD_W-1:0] word;
  logic [3:0]        cnt;

  xoshiro256ss_step u_step (
    .cur    (xo),
    .nxt    (xo_nxt),
    .result (word)
  );

`ifdef CRG_ZERO_SEED_CHECK_EN
  logic seed_zero;
  assign seed_zero = (seed == '0);
`else
  assign err_zero_seed = 1'b0;
`endif

  // Control FSM with registered outputs; generator state and result register update alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      dout  <= '0;
`ifdef CRG_ZERO_SEED_CHECK_EN
      err_zero_seed <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (run) begin
            // a new run invalidates the previous result immediately
            state <= LOAD;
            busy  <= 1'b1;
            valid <= 1'b0;
            dout  <= '0;
          end
        end
        LOAD: begin
          xo  <= xo_state_t'(seed);
          cnt <= '0;
`ifdef CRG_ZERO_SEED_CHECK_EN
          if (seed_zero) begin
            // all-zero state is a fixed point of the generator: flag it and skip the steps
            err_zero_seed <= 1'b1;
            state         <= FIN;
            busy          <= 1'b0;
            done          <= 1'b1;
          end else begin
            err_zero_seed <= 1'b0;
            state         <= STEP;
          end
`else
          state <= STEP;
`endif
        end
        STEP: begin
          dout[cnt*WORD_W +: WORD_W] <= word;
          xo  <= xo_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(N_WORDS - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crg_prg_expander.sv
// Purpose: self-checking bench for crg_prg_expander against a plain-arithmetic xoshiro256** model.
// Latency: checks done at cycle 14 (2 for trapped zero seed) and run restart every 15 cycles.
// Backpressure: checks that run is ignored while busy and in FIN.
module tb_crg_prg_expander;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic [255:0] seed = '0;
  logic         busy;
  logic         done;
  logic         valid;
  logic         err_zero_seed;
  logic [767:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]  busy_v;
  logic [15:0]  done_v;
  logic [767:0] d14;
  logic [767:0] d15;
  logic         v14;
  logic         e14;

  crg_prg_expander dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .err_zero_seed (err_zero_seed),
    .dout          (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rl(input logic [63:0] x, input int k);
    return (x << k) | (x >> (64 - k));
  endfunction

  // Reference: textbook xoshiro256** next() twelve times, using real multiplies
  function automatic logic [767:0] model(input logic [255:0] sd);
    logic [63:0]  s[4];
    logic [63:0]  t;
    logic [767:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) s[i] = sd[64*i +: 64];
    for (int w = 0; w < 12; w++) begin
      o[64*w +: 64] = rl(s[1] * 64'd5, 7) * 64'd9;
      t    = s[1] << 17;
      s[2] = s[2] ^ s[0];
      s[3] = s[3] ^ s[1];
      s[1] = s[1] ^ s[2];
      s[0] = s[0] ^ s[3];
      s[2] = s[2] ^ t;
      s[3] = rl(s[3], 45);
    end
    return o;
  endfunction

  function automatic logic [255:0] rnd_seed();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Pulse run in cycle 0 and record outputs for cycles 1..15
  task automatic run_one(input logic [255:0] sd, input bit repulse);
    @(negedge clk);
    seed = sd;
    run  = 1'b1;
    busy_v = '0;
    done_v = '0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      if (c == 1) run = 1'b0;
      if (c == 2) seed = rnd_seed();
      if (repulse) run = (c == 3 || c == 10);
      busy_v[c] = busy;
      done_v[c] = done;
      if (c == 14) begin
        d14 = dout;
        v14 = valid;
        e14 = err_zero_seed;
      end
      if (c == 15) d15 = dout;
    end
    run = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [255:0] sd);
    logic [767:0] ref_o;
    ref_o = model(sd);
`ifdef CRG_ZERO_SEED_CHECK_EN
    if (sd == '0) begin
      chk({tag, ".busy"}, busy_v, 16'h0002);
      chk({tag, ".done"}, done_v, 16'h0004);
      chk({tag, ".dout"}, d14, '0);
      chk({tag, ".valid"}, v14, 1'b0);
      chk({tag, ".err"}, e14, 1'b1);
      return;
    end
`endif
    chk({tag, ".busy"}, busy_v, 16'h3FFE);
    chk({tag, ".done"}, done_v, 16'h4000);
    chk({tag, ".dout"}, d14, ref_o);
    chk({tag, ".valid"}, v14, 1'b1);
    chk({tag, ".err"}, e14, 1'b0);
    chk({tag, ".hold"}, d15, ref_o);
  endtask

  initial begin
    logic [255:0] sd;
    logic [63:0]  done_h;
    logic [767:0] d29;
    logic         v16;

    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.valid", valid, 1'b0);
    chk("rst.err", err_zero_seed, 1'b0);
    chk("rst.dout", dout, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // s0 = 1: word0 = 0, word1 = 0x1680
    sd = 256'h1;
    run_one(sd, 1'b0);
    check_run("s0one", sd);
    chk("s0one.w0", d14[63:0], 64'h0);
    chk("s0one.w1", d14[127:64], 64'h1680);

    // s1 = 1: word0 = 0x1680
    sd = '0;
    sd[64] = 1'b1;
    run_one(sd, 1'b0);
    check_run("s1one", sd);
    chk("s1one.w0", d14[63:0], 64'h1680);

    // Reset in STEP at cycle 6 aborts at once
    sd = rnd_seed();
    @(negedge clk);
    seed = sd;
    run  = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.valid", valid, 1'b0);
    chk("abort.err", err_zero_seed, 1'b0);
    chk("abort.dout", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(sd, 1'b0);
    check_run("after_abort", sd);

    // run re-pulsed mid-run is ignored
    sd = rnd_seed();
    run_one(sd, 1'b1);
    check_run("repulse", sd);

    // zero seed (behaviour depends on build)
    run_one('0, 1'b0);
    check_run("zero", '0);

    // random seeds
    for (int k = 0; k < 6; k++) begin
      sd = rnd_seed();
      run_one(sd, 1'b0);
      check_run($sformatf("rnd%0d", k), sd);
    end

    // run held high: restart every 15 cycles
    sd = rnd_seed();
    done_h = '0;
    v16 = 1'b1;
    d29 = '0;
    @(negedge clk);
    seed = sd;
    run  = 1'b1;
    for (int c = 1; c < 46; c++) begin
      @(negedge clk);
      done_h[c] = done;
      if (c == 16) v16 = valid;
      if (c == 29) d29 = dout;
    end
    run = 1'b0;
    chk("held.done", done_h, (64'd1 << 14) | (64'd1 << 29) | (64'd1 << 44));
    chk("held.valid_load", v16, 1'b0);
    chk("held.dout", d29, model(sd));
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
